// File: rtl/stream_source_mc.sv
// Multi-channel packetised stream source: replays a pre-loaded beat table over
// valid/ready for a programmable number of passes, with packet gaps and abort.
module stream_source_mc #(
  parameter int    SIZE       = 256,
  parameter int    WIDTH      = 8,
  parameter int    CHANNELS   = 1,
  parameter int    PACKET     = 16,
  parameter int    GAP        = 0,
  parameter string INPUT_FILE = "",
  parameter int    SEED       = 123456789
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iStart,
  input  logic [15:0]               iRepeat,
  input  logic                      iAbort,
  output logic                      oValid_BM,
  input  logic                      iReady_BM,
  output logic [CHANNELS*WIDTH-1:0] oData_BM,
  output logic                      oLast_BM,
  output logic                      oBusy,
  output logic                      oDone
);

  localparam int DW = CHANNELS * WIDTH;
  localparam int AW = (SIZE > 1)   ? $clog2(SIZE)   : 1;
  localparam int PW = (PACKET > 1) ? $clog2(PACKET) : 1;
  localparam int GW = (GAP > 1)    ? $clog2(GAP)    : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN} state_t;
  typedef logic [SIZE-1:0][DW-1:0] table_t;

  function automatic table_t build_table();
    table_t t;
    integer seed;
    t = '0;
    seed = SEED;
    for (int e = 0; e < SIZE; e++)
      for (int c = 0; c < CHANNELS; c++)
        t[e][c*WIDTH +: WIDTH] = WIDTH'($random(seed));
    return t;
  endfunction

  // NOTE: the table is a ROM set by its initializer; reset never touches memory contents.
  table_t table_q = build_table();

  state_t        state;
  logic [AW-1:0] raddr;
  logic [PW-1:0] pkt_cnt;
  logic [15:0]   pass_cnt;
  logic [15:0]   repeat_q;
  logic [GW-1:0] gap_cnt;
  logic          valid_q;
  logic          last_q;
  logic          end_q;
  logic          done_q;
  logic [DW-1:0] data_q;

  logic          xfer;
  logic          done_beat;
  logic          load;
  logic [AW-1:0] fetch_addr;
  logic [AW-1:0] next_addr;
  logic [PW-1:0] fetch_pkt;
  logic [PW-1:0] next_pkt;
  logic          fetch_last;
  logic          fetch_end;

  // raddr/pkt_cnt point at the next beat to fetch; a start always fetches entry 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    load       = 1'b0;
    xfer       = valid_q && iReady_BM;
    done_beat  = xfer && end_q && (repeat_q != '0) && ((pass_cnt + 16'd1) == repeat_q);
    fetch_addr = (state == S_IDLE) ? '0 : raddr;
    fetch_pkt  = (state == S_IDLE) ? '0 : pkt_cnt;
    fetch_end  = (fetch_addr == AW'(SIZE - 1));
    fetch_last = fetch_end || (fetch_pkt == PW'(PACKET - 1));
    next_addr  = fetch_end  ? '0 : fetch_addr + AW'(1);
    next_pkt   = fetch_last ? '0 : fetch_pkt + PW'(1);
    unique case (state)
      S_IDLE:  load = iStart;
      S_RUN:   load = !iAbort && !done_beat && !(xfer && last_q && (GAP > 0))
                      && (!valid_q || xfer);
      S_GAP:   load = !iAbort && (gap_cnt == GW'(GAP - 1));
      default: load = 1'b0;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= S_IDLE;
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      end_q    <= 1'b0;
      done_q   <= 1'b0;
      raddr    <= '0;
      pkt_cnt  <= '0;
      pass_cnt <= '0;
      gap_cnt  <= '0;
      repeat_q <= '0;
    end else begin
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= table_q[fetch_addr];
        last_q  <= fetch_last;
        end_q   <= fetch_end;
        raddr   <= next_addr;
        pkt_cnt <= next_pkt;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end

      if (xfer && end_q) pass_cnt <= pass_cnt + 16'd1;

      unique case (state)
        S_IDLE: begin
          if (iStart) begin
            state    <= S_RUN;
            repeat_q <= iRepeat;
            done_q   <= 1'b0;
            pass_cnt <= '0;
            gap_cnt  <= '0;
          end
        end
        S_RUN: begin
          // Abort wins, but a beat completing the run on the same edge still reports done.
          if (iAbort) begin
            state <= (valid_q && !xfer) ? S_DRAIN : S_IDLE;
            if (done_beat) done_q <= 1'b1;
          end else if (done_beat) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end else if (xfer && last_q && (GAP > 0)) begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end
        S_GAP: begin
          if (iAbort)    state   <= S_IDLE;
          else if (load) state   <= S_RUN;
          else           gap_cnt <= gap_cnt + GW'(1);
        end
        S_DRAIN: begin
          if (xfer) begin
            state <= S_IDLE;
            if (done_beat) done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign oValid_BM = valid_q;
  assign oData_BM  = data_q;
  assign oLast_BM  = last_q;
  assign oBusy     = (state != S_IDLE);
  assign oDone     = done_q;

endmodule
